// File: rtl/qk_inst_sequencer.sv
// qk_inst_sequencer: on-chip initiator that replays the attention-core flow
// (Q write, K write, K load, execute, ofifo->pmem drain) after one start pulse.
// Every inst word is registered, so it reflects the FSM state one cycle earlier.
module qk_inst_sequencer #(
  parameter int bw          = 8,
  parameter int pr          = 16,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap_ld      = 2,
  parameter int gap_ex      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [pr*bw-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [pr*bw-1:0] mem_in,
  output logic [16:0]      inst,
  output logic             busy,
  output logic             done
);

  localparam int CW = 8;
  localparam logic [CW-1:0] TC = CW'(total_cycle);
  localparam logic [CW-1:0] CL = CW'(col);
  localparam logic [CW-1:0] GL = CW'(gap_ld);
  localparam logic [CW-1:0] GE = CW'(gap_ex);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef struct packed {
    logic       ofifo_rd;
    logic [3:0] qkmem_add;
    logic [3:0] pmem_add;
    logic       execute;
    logic       load;
    logic       qmem_rd;
    logic       qmem_wr;
    logic       kmem_rd;
    logic       kmem_wr;
    logic       pmem_rd;
    logic       pmem_wr;
  } inst_t;

  typedef enum logic [3:0] {
    IDLE, QWR, QGAP, KWR, GAPL, KLD, EXGAP1, EXE, EXGAP2, DRN, FIN
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, lim, glen;
  inst_t           inst_r, inst_n;
  logic [pr*bw-1:0] mem_r, mem_n;
  logic            busy_r, busy_n, done_r, done_n;

  // State, counter and registered outputs; reset aborts any run in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      inst_r <= '0;
      mem_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      inst_r <= inst_n;
      mem_r  <= mem_n;
      busy_r <= busy_n;
      done_r <= done_n;
    end
  end

  // Next state plus the inst word to present on the following cycle.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    inst_n     = '0;
    mem_n      = mem_r;
    busy_n     = busy_r;
    done_n     = 1'b0;
    data_ready = 1'b0;
    lim        = (state == QWR) ? TC : CL;
    glen       = (state == GAPL) ? GL : GE;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = QWR;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end
      QWR, KWR: begin
        data_ready = (cnt < lim);
        if (data_valid && data_ready) begin
          mem_n            = data_in;
          inst_n.qkmem_add = cnt[3:0];
          inst_n.qmem_wr   = (state == QWR);
          inst_n.kmem_wr   = (state == KWR);
          cnt_n            = cnt + ONE;
          if (cnt == lim - ONE) begin
            state_n = (state == QWR) ? QGAP : GAPL;
            cnt_n   = '0;
          end
        end else begin
          // stall: keep the last address so the memory port sees no jump
          inst_n.qkmem_add = inst_r.qkmem_add;
        end
      end
      QGAP: begin
        state_n = KWR;
        cnt_n   = '0;
      end
      GAPL, EXGAP1, EXGAP2: begin
        if (cnt == glen - ONE) begin
          cnt_n   = '0;
          state_n = (state == GAPL) ? KLD : (state == EXGAP1) ? EXE : DRN;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      KLD: begin
        // k=0 primes the load path, k=1..col read K rows, k=col+1 flushes,
        // k=col+2 drops load before the execute gap
        inst_n.load = (cnt <= CL + ONE);
        if (cnt >= ONE && cnt <= CL) begin
          inst_n.kmem_rd   = 1'b1;
          inst_n.qkmem_add = 4'(cnt - ONE);
        end
        if (cnt == CL + ONE + ONE) begin
          state_n = EXGAP1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      EXE: begin
        if (cnt < TC) begin
          inst_n.execute   = 1'b1;
          inst_n.qmem_rd   = 1'b1;
          inst_n.qkmem_add = cnt[3:0];
          cnt_n            = cnt + ONE;
        end else begin
          state_n = EXGAP2;
          cnt_n   = '0;
        end
      end
      DRN: begin
        if (cnt < TC) begin
          inst_n.ofifo_rd = 1'b1;
          inst_n.pmem_wr  = 1'b1;
          inst_n.pmem_add = cnt[3:0];
          cnt_n           = cnt + ONE;
        end else begin
          state_n = FIN;
          cnt_n   = '0;
        end
      end
      FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign inst   = inst_r;
  assign mem_in = mem_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: doc/qk_inst_sequencer.md
Name: qk_inst_sequencer

Overview:
- On-chip initiator for the fullchip instruction/data interface (17-bit inst word plus pr*bw mem_in bus).
- Autonomously replays the full attention-core flow on a single start pulse: Q write, K write, K load, execute, then ofifo-to-pmem drain.
- Q/K vectors arrive from a host-side valid/ready stream.
- Sits in front of fullchip, replacing host-driven instruction stepping.

Parameters:
- bw, 8, Q/K element bit width
- pr, 16, elements per vector; mem_in width = pr*bw
- col, 8, number of K vectors / dot-product units (1..16)
- total_cycle, 8, number of Q vectors (1..16)
- gap_ld, 2, idle cycles between K write and K load
- gap_ex, 10, idle cycles after K load and after execute

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request to run the full sequence; ignored unless idle
- data_in  in  pr*bw  host Q/K vector, element j at [j*bw +: bw]
- data_valid  in  1  data_in valid
- data_ready  out  1  sequencer accepts a vector this cycle
- mem_in  out  pr*bw  data bus to fullchip
- inst  out  17  instruction word to fullchip
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence completion

Behaviour:
- One clock; reset is synchronous and active-high.
- inst bit map: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr. pmem_rd is always 0.
- inst, mem_in, busy and done are registers.
- Reset values: inst=0, mem_in=0, busy=0, done=0, data_ready=0. FSM goes to IDLE and all counters clear.
- Reset mid-sequence aborts the run. inst=0 on the following cycle and no done pulse is issued.
- States: IDLE, QWR, QGAP, KWR, GAPL, KLD, EXGAP1, EXE, EXGAP2, DRN, FIN.
- IDLE:
  - inst=0.
  - start=1 -> QWR, busy=1 next cycle.
  - start while busy has no effect.
- QWR:
  - data_ready=1 while fewer than total_cycle vectors have been accepted.
  - Acceptance (data_valid&data_ready at an edge) -> next cycle inst has qmem_wr=1, qkmem_add = accept index (0..total_cycle-1), mem_in=data_in.
  - Stall (valid low) -> that following cycle has qmem_wr=0, address held, mem_in held.
  - After the last acceptance and its write cycle -> QGAP (1 cycle, inst=0) -> KWR.
- KWR: identical to QWR using kmem_wr, col vectors, addresses 0..col-1. Then -> GAPL.
- GAPL: inst=0 for gap_ld cycles.
- KLD spans col+2 cycles, load=1 throughout:
  - k=0: kmem_rd=0, add 0.
  - k=1: kmem_rd=1, add 0.
  - k=2..col: kmem_rd=1, add k-1.
  - k=col+1: kmem_rd=0, add 0.
  - Then one cycle with inst=0 (load drops).
- EXGAP1: inst=0 for gap_ex cycles.
- EXE:
  - total_cycle cycles with execute=1, qmem_rd=1, qkmem_add 0..total_cycle-1 incrementing by 1 per cycle.
  - Then one cycle with inst=0.
- EXGAP2: inst=0 for gap_ex cycles.
- DRN:
  - total_cycle cycles with ofifo_rd=1, pmem_wr=1, pmem_add 0..total_cycle-1.
  - Then one cycle with inst=0.
- FIN: done=1 for one cycle, busy drops the same cycle, -> IDLE.
- data_ready is 0 outside QWR/KWR. Vectors offered outside those states are not consumed.
- All address fields are 4 bits. Fields not active in a state are 0. mem_in holds its last written value outside write cycles.

Test Plan:
- Reset, then start with data_valid tied high and vectors Q0..Q7, K0..K7 (element j of vector v = v*16+j) -> 8 qmem_wr cycles at add 0..7 carrying matching mem_in; 1 zero cycle; 8 kmem_wr cycles at add 0..7; done exactly once.
- Same run with defaults -> load=1 for exactly 10 consecutive cycles, kmem_rd=1 for 8 with add 0..7; execute=qmem_rd=1 for 8 cycles with add 0..7; ofifo_rd=pmem_wr=1 for 8 cycles with pmem_add 0..7; gaps of 2/10/10 zero cycles.
- data_valid toggling 1,0,0,1,... during QWR -> qmem_wr pulses only after accepted vectors; qkmem_add still strictly 0..7 with no skips or repeats.
- start pulsed again during EXE, and data offered during EXE -> ignored; data_ready=0; sequence timing unchanged.
- reset asserted during KLD -> next cycle inst=0, busy=0, no done; new start replays from QWR with add 0.
- total_cycle=3, col=2 -> 3 Q writes, 2 K writes, load high 4 cycles, 3 execute cycles, 3 drain cycles, done once.
